// File: rtl/axi_dual_burst_bridge.sv
// axi_dual_burst_bridge: cache-to-AXI3 master with independent read and write engines,
// so a dirty-block write-back and a refill can be in flight together.
module axi_dual_burst_bridge #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int BLOCK_WORDS = 8,
    parameter int ID_W        = 4,
    parameter int RD_ID       = 0,
    parameter int WR_ID       = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [1:0]                    req_op_i,
    input  logic [ADDR_W-1:0]             req_addr_i,
    input  logic [2:0]                    req_size_i,
    input  logic [DATA_W/8-1:0]           req_wstrb_i,
    input  logic [BLOCK_WORDS*DATA_W-1:0] req_wdata_i,
    output logic                          rd_done_o,
    output logic [BLOCK_WORDS*DATA_W-1:0] rd_data_o,
    output logic                          rd_err_o,
    output logic                          wr_done_o,
    output logic                          wr_err_o,
    output logic [ID_W-1:0]               arid_o,
    output logic [ADDR_W-1:0]             araddr_o,
    output logic [3:0]                    arlen_o,
    output logic [2:0]                    arsize_o,
    output logic [1:0]                    arburst_o,
    output logic [1:0]                    arlock_o,
    output logic [3:0]                    arcache_o,
    output logic [2:0]                    arprot_o,
    output logic                          arvalid_o,
    input  logic                          arready_i,
    input  logic [ID_W-1:0]               rid_i,
    input  logic [DATA_W-1:0]             rdata_i,
    input  logic [1:0]                    rresp_i,
    input  logic                          rlast_i,
    input  logic                          rvalid_i,
    output logic                          rready_o,
    output logic [ID_W-1:0]               awid_o,
    output logic [ADDR_W-1:0]             awaddr_o,
    output logic [3:0]                    awlen_o,
    output logic [2:0]                    awsize_o,
    output logic [1:0]                    awburst_o,
    output logic [1:0]                    awlock_o,
    output logic [3:0]                    awcache_o,
    output logic [2:0]                    awprot_o,
    output logic                          awvalid_o,
    input  logic                          awready_i,
    output logic [ID_W-1:0]               wid_o,
    output logic [DATA_W-1:0]             wdata_o,
    output logic [DATA_W/8-1:0]           wstrb_o,
    output logic                          wlast_o,
    output logic                          wvalid_o,
    input  logic                          wready_i,
    input  logic [ID_W-1:0]               bid_i,
    input  logic [1:0]                    bresp_i,
    input  logic                          bvalid_i,
    output logic                          bready_o
);
    localparam int WB = DATA_W / 8;
    localparam int OFF = $clog2(BLOCK_WORDS * WB);
    localparam int BDW = BLOCK_WORDS * DATA_W;
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(BLOCK_WORDS * WB - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(WB - 1);
    localparam logic [3:0] BLK_LEN = 4'(BLOCK_WORDS - 1);
    localparam logic [2:0] WSIZE = 3'($clog2(WB));

    typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_DATA} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_ADDR_DATA, WR_B} wr_state_t;

    rd_state_t         rd_state_q;
    wr_state_t         wr_state_q;
    logic              arvalid_q, rready_q, ovf_q, rerr_q, rd_done_q, rd_err_q;
    logic [ADDR_W-1:0] araddr_q, awaddr_q;
    logic [3:0]        arlen_q, awlen_q, cnt_q, widx_q;
    logic [2:0]        arsize_q, awsize_q;
    logic [BDW-1:0]    rbuf_q, rbuf_d, rd_data_q, wbuf_q;
    logic              awvalid_q, wvalid_q, wlast_q, bready_q, wr_done_q, wr_err_q;
    logic [WB-1:0]     wstrb_q;
    logic              hazard, rd_acc, wr_acc, aw_pend, w_pend;
    logic              unused_ids;

    assign unused_ids = ^{rid_i, bid_i};

    // A load may not overtake a pending write-back of the same block.
    assign hazard = (wr_state_q != WR_IDLE) && (req_addr_i[ADDR_W-1:OFF] == awaddr_q[ADDR_W-1:OFF]);
    assign req_ready_o = req_op_i[1] ? (wr_state_q == WR_IDLE) : (rd_state_q == RD_IDLE && !hazard);
    assign rd_acc = req_valid_i && req_ready_o && !req_op_i[1];
    assign wr_acc = req_valid_i && req_ready_o && req_op_i[1];

    assign arid_o    = ID_W'(RD_ID);
    assign awid_o    = ID_W'(WR_ID);
    assign wid_o     = ID_W'(WR_ID);
    assign arburst_o = 2'b01;
    assign awburst_o = 2'b01;
    assign arlock_o  = 2'b00;
    assign awlock_o  = 2'b00;
    assign arcache_o = 4'b0010;
    assign awcache_o = 4'b0010;
    assign arprot_o  = 3'b000;
    assign awprot_o  = 3'b000;

    assign araddr_o  = araddr_q;
    assign arlen_o   = arlen_q;
    assign arsize_o  = arsize_q;
    assign arvalid_o = arvalid_q;
    assign rready_o  = rready_q;
    assign rd_done_o = rd_done_q;
    assign rd_err_o  = rd_err_q;
    assign rd_data_o = rd_data_q;
    assign awaddr_o  = awaddr_q;
    assign awlen_o   = awlen_q;
    assign awsize_o  = awsize_q;
    assign awvalid_o = awvalid_q;
    assign wdata_o   = wbuf_q[DATA_W-1:0];
    assign wstrb_o   = wstrb_q;
    assign wlast_o   = wlast_q;
    assign wvalid_o  = wvalid_q;
    assign bready_o  = bready_q;
    assign wr_done_o = wr_done_q;
    assign wr_err_o  = wr_err_q;

    always_comb begin
        rbuf_d = rbuf_q;
        if (!ovf_q) rbuf_d[cnt_q*DATA_W +: DATA_W] = rdata_i;
    end

    // Beats are collected in rbuf so rd_data only changes when a load completes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state_q <= RD_IDLE;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
            rready_q   <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            rerr_q     <= 1'b0;
            rbuf_q     <= '0;
            rd_data_q  <= '0;
            rd_done_q  <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_done_q <= 1'b0;
            case (rd_state_q)
                RD_IDLE: if (rd_acc) begin
                    rd_state_q <= RD_AR;
                    arvalid_q  <= 1'b1;
                    araddr_q   <= req_op_i[0] ? (req_addr_i & BLK_MASK) : req_addr_i;
                    arlen_q    <= req_op_i[0] ? BLK_LEN : 4'd0;
                    arsize_q   <= req_op_i[0] ? WSIZE : req_size_i;
                    rbuf_q     <= '0;
                end
                RD_AR: if (arready_i) begin
                    rd_state_q <= RD_DATA;
                    arvalid_q  <= 1'b0;
                    rready_q   <= 1'b1;
                    cnt_q      <= '0;
                    ovf_q      <= 1'b0;
                    rerr_q     <= 1'b0;
                end
                RD_DATA: if (rvalid_i) begin
                    rbuf_q <= rbuf_d;
                    rerr_q <= rerr_q | (rresp_i != 2'b00);
                    if (rlast_i) begin
                        rd_state_q <= RD_IDLE;
                        rready_q   <= 1'b0;
                        rd_done_q  <= 1'b1;
                        rd_data_q  <= rbuf_d;
                        rd_err_q   <= rerr_q | (rresp_i != 2'b00) | ovf_q | (cnt_q != arlen_q);
                    end else if (cnt_q == arlen_q) begin
                        ovf_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign aw_pend = awvalid_q && !awready_i;
    assign w_pend  = wvalid_q && !(wready_i && wlast_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state_q <= WR_IDLE;
            awvalid_q  <= 1'b0;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            awsize_q   <= '0;
            wvalid_q   <= 1'b0;
            wbuf_q     <= '0;
            wstrb_q    <= '0;
            wlast_q    <= 1'b0;
            widx_q     <= '0;
            bready_q   <= 1'b0;
            wr_done_q  <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            wr_done_q <= 1'b0;
            case (wr_state_q)
                WR_IDLE: if (wr_acc) begin
                    wr_state_q <= WR_ADDR_DATA;
                    awvalid_q  <= 1'b1;
                    wvalid_q   <= 1'b1;
                    awaddr_q   <= req_addr_i & (req_op_i[0] ? BLK_MASK : WORD_MASK);
                    awlen_q    <= req_op_i[0] ? BLK_LEN : 4'd0;
                    awsize_q   <= req_op_i[0] ? WSIZE : req_size_i;
                    wstrb_q    <= req_op_i[0] ? '1 : req_wstrb_i;
                    wbuf_q     <= req_wdata_i;
                    wlast_q    <= !req_op_i[0];
                    widx_q     <= '0;
                end
                WR_ADDR_DATA: begin
                    if (awvalid_q && awready_i) awvalid_q <= 1'b0;
                    if (wvalid_q && wready_i) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                        end else begin
                            wbuf_q  <= wbuf_q >> DATA_W;
                            widx_q  <= widx_q + 4'd1;
                            wlast_q <= (widx_q + 4'd1 == awlen_q);
                        end
                    end
                    if (!aw_pend && !w_pend) begin
                        wr_state_q <= WR_B;
                        bready_q   <= 1'b1;
                    end
                end
                WR_B: if (bvalid_i) begin
                    wr_state_q <= WR_IDLE;
                    bready_q   <= 1'b0;
                    wr_done_q  <= 1'b1;
                    wr_err_q   <= (bresp_i != 2'b00);
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end
endmodule
